// File: rtl/vga_stream_ctrl.sv
// Pixel-side stream controller: arms on a full FIFO in vblank, streams pixels,
// and recovers from underflow by draining to the next frame. Optional counter: VGA_STREAM_UNDERFLOW_CNT_EN.
module vga_stream_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  input  logic             fifo_wfull_async,
  input  logic             fifo_rempty,
  input  logic             de,
  input  logic             vblank,
  output logic             fifo_read,
  output logic             stream_on,
  output logic             underflow,
  output logic             frame_restart,
  output logic [CNT_W-1:0] underflow_cnt,
  output logic [1:0]       state_dbg_o
);

  // Handshake: fifo_read is a single-cycle pop; the FIFO accepts it whenever
  // fifo_rempty is low in that same cycle, so fifo_read is never raised while empty.

  typedef enum logic [1:0] {
    WAIT_FILL = 2'd0,
    ARMED     = 2'd1,
    STREAM    = 2'd2,
    RESYNC    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] wfull_sync_q;
  logic                   wfull_s;
  logic                   vblank_d;
  logic                   vbl_rise, vbl_fall;
  logic                   underflow_q, underflow_d;
  logic                   frame_restart_q;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      wfull_sync_q <= '0;
      vblank_d     <= 1'b0;
    end else begin
      wfull_sync_q <= {wfull_sync_q[SYNC_STAGES-2:0], fifo_wfull_async};
      vblank_d     <= vblank;
    end
  end

  assign wfull_s  = wfull_sync_q[SYNC_STAGES-1];
  assign vbl_rise = vblank & ~vblank_d;
  assign vbl_fall = ~vblank & vblank_d;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q         <= WAIT_FILL;
      underflow_q     <= 1'b0;
      frame_restart_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      underflow_q     <= underflow_d;
      frame_restart_q <= (state_d == RESYNC);
    end
  end

  always_comb begin
    state_d     = state_q;
    underflow_d = 1'b0;
    fifo_read   = 1'b0;
    stream_on   = 1'b0;
    unique case (state_q)
      WAIT_FILL: begin
        if (wfull_s && vblank) state_d = ARMED;
      end
      ARMED: begin
        if (vbl_fall) state_d = STREAM;
      end
      STREAM: begin
        stream_on = 1'b1;
        fifo_read = de & ~fifo_rempty;
        if (de && fifo_rempty) begin
          underflow_d = 1'b1;
          state_d     = RESYNC;
        end
      end
      RESYNC: begin
        // Discard the rest of the broken frame; restart only once the FIFO is empty at a frame boundary.
        fifo_read = ~fifo_rempty;
        if (vbl_rise && fifo_rempty) state_d = WAIT_FILL;
      end
      default: state_d = WAIT_FILL;
    endcase
  end

  assign underflow     = underflow_q;
  assign frame_restart = frame_restart_q;
  assign state_dbg_o   = state_q;

`ifdef VGA_STREAM_UNDERFLOW_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      cnt_q <= '0;
    end else if (underflow_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign underflow_cnt = cnt_q;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: doc/vga_stream_ctrl.md
VGA_STREAM_CTRL -- requirements
Module: vga_stream_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronising fifo_wfull_async into pixel_clk (legal 2..4).
REQ-002 SHALL have parameter CNT_W, default 16, width of underflow_cnt.
REQ-003 SHALL have port pixel_clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 SHALL have port pixel_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fifo_wfull_async  input  1  pixel FIFO full flag from the Wishbone clock domain; unsynchronised.
REQ-006 SHALL have port fifo_rempty  input  1  pixel FIFO empty, pixel_clk domain.
REQ-007 SHALL have port de  input  1  display enable; the current pixel_clk cycle is an active pixel.
REQ-008 SHALL have port vblank  input  1  high during vertical blanking; the timing generator drives it.
REQ-009 SHALL have port fifo_read  output  1  pop request to the pixel FIFO.
REQ-010 SHALL have port stream_on  output  1  high while FIFO data is valid video; low means force black.
REQ-011 SHALL have port underflow  output  1  one-cycle pulse per underflow event.
REQ-012 SHALL have port frame_restart  output  1  level request to the fetch side to restart at frame address 0.
REQ-013 SHALL have port underflow_cnt  output  CNT_W  saturating count of underflow events.

Function
REQ-014 SHALL synchronise fifo_wfull_async through SYNC_STAGES flops into wfull_s; only wfull_s is used internally.
REQ-015 SHALL register vblank into vblank_d; vbl_rise = vblank & !vblank_d; vbl_fall = !vblank & vblank_d.
REQ-016 SHALL implement the FSM states WAIT_FILL, ARMED, STREAM and RESYNC, with a registered state register.
REQ-017 WAIT_FILL: fifo_read=0, stream_on=0; go to ARMED when wfull_s=1 and vblank=1 in the same cycle.
REQ-018 ARMED: fifo_read=0, stream_on=0; go to STREAM on vbl_fall; stay in ARMED through further vblank cycles.
REQ-019 STREAM: stream_on=1; fifo_read = de & !fifo_rempty, combinational from the state, de and fifo_rempty.
REQ-020 STREAM: de=1 with fifo_rempty=1 is an underflow; next cycle underflow=1 for exactly one cycle and state=RESYNC.
REQ-021 STREAM: de=0 cycles, including all blanking, SHALL never pop.
REQ-022 RESYNC: stream_on=0, frame_restart=1, fifo_read = !fifo_rempty (drain and discard).
REQ-023 RESYNC: go to WAIT_FILL on the first vbl_rise seen with fifo_rempty=1; a vbl_rise with fifo_rempty=0 is ignored, and the FSM waits for the next frame.
REQ-024 frame_restart SHALL be registered and high exactly while in RESYNC.
REQ-025 A further underflow condition inside RESYNC SHALL NOT pulse underflow again.
REQ-026 underflow_cnt SHALL increment by 1 per underflow pulse and saturate at all-ones without wrapping.

Reset
REQ-027 pixel_rst=1 SHALL asynchronously force state=WAIT_FILL, all sync flops=0 and vblank_d=0.
REQ-028 pixel_rst=1 SHALL asynchronously force stream_on=0, underflow=0, frame_restart=0 and underflow_cnt=0; fifo_read=0 follows from the state.
REQ-029 Reset asserted mid-STREAM or mid-RESYNC SHALL abandon the operation; no underflow pulse is generated by reset.

Configuration
REQ-030 Macro VGA_STREAM_UNDERFLOW_CNT_EN defined: the underflow_cnt counter per REQ-026 is compiled in.
REQ-031 Macro VGA_STREAM_UNDERFLOW_CNT_EN undefined: no counter logic; underflow_cnt is tied to 0; port list unchanged; all other behaviour identical.

Verification
REQ-032 Reset released, then vblank=1 and fifo_wfull_async=1 -> ARMED reached SYNC_STAGES+1 cycles later; fifo_read=0 throughout; stream_on=1 on the cycle after vblank falls.
REQ-033 STREAM, fifo_rempty=0, de pattern 1,1,0,1 -> fifo_read 1,1,0,1 in the same cycles; no pops during vblank.
REQ-034 STREAM, de=1 with fifo_rempty=1 at cycle T -> underflow=1 only at T+1; frame_restart=1 and stream_on=0 from T+1; fifo_read mirrors !fifo_rempty.
REQ-035 RESYNC: vbl_rise with fifo_rempty=0 -> stays in RESYNC; next vbl_rise with fifo_rempty=1 -> WAIT_FILL and frame_restart=0 next cycle.
REQ-036 With the macro defined: 3 underflows -> underflow_cnt=3; preloaded to 0xFFFF plus 1 underflow -> remains 0xFFFF; without the macro -> remains 0.
REQ-037 pixel_rst pulsed mid-STREAM while de=1 -> in the same cycle, fifo_read=0 and stream_on=0; after release the FSM is in WAIT_FILL.
